circle_draw: RTL and testbench

- Bresenham midpoint circle rasteriser for the 160x120 VGA adapter path.
- Sits between the lab-level control FSM and the VGA adapter; the control FSM clears the screen, then pulses this block.
- Emits one candidate pixel per clock (vga_x, vga_y, vga_colour, vga_plot) for all eight octants, clips off-screen points, and signals completion with a start/done handshake.

---
 rtl/circle_pkg.sv | 34 +++
 rtl/circle_draw_if.sv | 29 ++
 rtl/circle_octant_pt.sv | 52 +++++
 rtl/circle_draw.sv | 138 +++++++++++++
 tb/tb_circle_draw.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/circle_pkg.sv
// Shared types and constants for the midpoint circle rasteriser.
// Latency: none (package only).
// Backpressure: none (package only).
package circle_pkg;

    localparam int SCREEN_W_DFLT = 160;
    localparam int SCREEN_H_DFLT = 120;

    localparam int COORD_W = 10;  // signed, wide enough for 255+255 and 0-255
    localparam int CRIT_W  = 12;  // signed decision variable
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int R_W     = 8;
    localparam int C_W     = 3;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [CRIT_W-1:0]  crit_t;

    // Octant states occupy 8..15 so bit 3 flags "emitting" and bits 2:0
    // are the octant index directly.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        DONE = 4'd1,
        OCT0 = 4'd8,
        OCT1 = 4'd9,
        OCT2 = 4'd10,
        OCT3 = 4'd11,
        OCT4 = 4'd12,
        OCT5 = 4'd13,
        OCT6 = 4'd14,
        OCT7 = 4'd15
    } state_t;

endpackage

// File: rtl/circle_draw_if.sv
// Request/response and VGA pixel bundle for circle_draw.
// Latency: wires only.
// Backpressure: none; start is level-held until done is seen.
// master: requester side (drives start and draw parameters, sees done and
// the pixel stream). slave: the rasteriser.
interface circle_draw_if;
    import circle_pkg::*;

    logic           start;
    logic [C_W-1:0] colour;
    logic [X_W-1:0] centre_x;
    logic [Y_W-1:0] centre_y;
    logic [R_W-1:0] radius;
    logic           done;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           vga_plot;

    modport master (
        output start, colour, centre_x, centre_y, radius,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, colour, centre_x, centre_y, radius,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/circle_octant_pt.sv
// Maps one octant offset (ox,oy) around centre (cx,cy) to a signed point + clip flag.
// Latency: combinational.
// Backpressure: none.
// Ports: oct_i octant index, cx_i/cy_i centre, ox_i/oy_i signed offsets,
// x_o/y_o signed point, on_screen_o set when the point lies inside the screen.
module circle_octant_pt
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DFLT,
    parameter int SCREEN_H = SCREEN_H_DFLT
) (
    input  logic [2:0]     oct_i,
    input  logic [X_W-1:0] cx_i,
    input  logic [Y_W-1:0] cy_i,
    input  coord_t         ox_i,
    input  coord_t         oy_i,
    output coord_t         x_o,
    output coord_t         y_o,
    output logic           on_screen_o
);

    localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

    coord_t cx_s;
    coord_t cy_s;

    // Zero-extend the unsigned centre into the signed working width.
    assign cx_s = coord_t'({{(COORD_W-X_W){1'b0}}, cx_i});
    assign cy_s = coord_t'({{(COORD_W-Y_W){1'b0}}, cy_i});

    always_comb begin
        x_o = cx_s + ox_i;
        y_o = cy_s + oy_i;
        case (oct_i)
            3'd0: begin x_o = cx_s + ox_i; y_o = cy_s + oy_i; end
            3'd1: begin x_o = cx_s + oy_i; y_o = cy_s + ox_i; end
            3'd2: begin x_o = cx_s - ox_i; y_o = cy_s + oy_i; end
            3'd3: begin x_o = cx_s - oy_i; y_o = cy_s + ox_i; end
            3'd4: begin x_o = cx_s - ox_i; y_o = cy_s - oy_i; end
            3'd5: begin x_o = cx_s - oy_i; y_o = cy_s - ox_i; end
            3'd6: begin x_o = cx_s + ox_i; y_o = cy_s - oy_i; end
            3'd7: begin x_o = cx_s + oy_i; y_o = cy_s - ox_i; end
            default: begin x_o = cx_s + ox_i; y_o = cy_s + oy_i; end
        endcase
    end

    // Sign bit clear means >= 0.
    assign on_screen_o = !x_o[COORD_W-1] && (x_o <= X_MAX) &&
                         !y_o[COORD_W-1] && (y_o <= Y_MAX);

endmodule

// File: rtl/circle_draw.sv
// Midpoint circle rasteriser: one candidate pixel per clock, eight octants per step.
// Latency: first pixel the cycle after start is seen; done the cycle after the last OCT7.
// Backpressure: none; start is level-held, done held until start drops.
// Ports: clk, rst (sync, active-high), dif slave bundle carrying
// start/colour/centre_x/centre_y/radius in and done/vga_x/vga_y/vga_colour/vga_plot out.
module circle_draw
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DFLT,
    parameter int SCREEN_H = SCREEN_H_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    circle_draw_if.slave dif
);

    state_t         state_q, state_d;
    logic [C_W-1:0] col_q,   col_d;
    logic [X_W-1:0] cx_q,    cx_d;
    logic [Y_W-1:0] cy_q,    cy_d;
    coord_t         ox_q,    ox_d;
    coord_t         oy_q,    oy_d;
    crit_t          crit_q,  crit_d;

    logic [3:0] st_bits;
    coord_t     oy_n;
    coord_t     ox_n;
    crit_t      oy_c;
    crit_t      ox_c;

    coord_t pt_x;
    coord_t pt_y;
    logic   pt_on;

    assign st_bits = state_q;

    circle_octant_pt #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_pt (
        .oct_i       (st_bits[2:0]),
        .cx_i        (cx_q),
        .cy_i        (cy_q),
        .ox_i        (ox_q),
        .oy_i        (oy_q),
        .x_o         (pt_x),
        .y_o         (pt_y),
        .on_screen_o (pt_on)
    );

    // Off-screen points still drive the low bits; the high bits only feed the clip.
    logic unused_pt_hi;
    assign unused_pt_hi = ^{pt_x[COORD_W-1:X_W], pt_y[COORD_W-1:Y_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            crit_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            crit_q  <= crit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        crit_d  = crit_q;
        oy_n    = oy_q + coord_t'(1);
        ox_n    = ox_q - coord_t'(1);
        oy_c    = crit_t'(oy_n);
        ox_c    = crit_t'(ox_n);

        case (state_q)
            IDLE: begin
                if (dif.start) begin
                    state_d = OCT0;
                    col_d   = dif.colour;
                    cx_d    = dif.centre_x;
                    cy_d    = dif.centre_y;
                    ox_d    = coord_t'({{(COORD_W-R_W){1'b0}}, dif.radius});
                    oy_d    = '0;
                    crit_d  = crit_t'(1) - crit_t'({{(CRIT_W-R_W){1'b0}}, dif.radius});
                end
            end
            OCT7: begin
                oy_d = oy_n;
                if (crit_q[CRIT_W-1] || (crit_q == '0)) begin
                    crit_d = crit_q + (oy_c <<< 1) + crit_t'(1);
                    // x unchanged: continue while oy' <= ox
                    state_d = (oy_n <= ox_q) ? OCT0 : DONE;
                end else begin
                    ox_d   = ox_n;
                    crit_d = crit_q + ((oy_c - ox_c) <<< 1) + crit_t'(1);
                    state_d = (oy_n <= ox_n) ? OCT0 : DONE;
                end
            end
            DONE: begin
                if (!dif.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // OCT0..OCT6 step through consecutive encodings.
                state_d = state_t'(st_bits + 4'd1);
            end
        endcase
    end

    always_comb begin
        dif.vga_x      = '0;
        dif.vga_y      = '0;
        dif.vga_colour = '0;
        dif.vga_plot   = 1'b0;
        dif.done       = (state_q == DONE);
        if (st_bits[3]) begin
            dif.vga_x      = pt_x[X_W-1:0];
            dif.vga_y      = pt_y[Y_W-1:0];
            dif.vga_colour = col_q;
            dif.vga_plot   = pt_on;
        end
    end

endmodule

// File: tb/tb_circle_draw.sv
module tb_circle_draw;
    import circle_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    circle_draw_if dif ();

    circle_draw #(
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // {done, plot, x[7:0], y[6:0], colour}
    function automatic logic [19:0] pack(input bit dn, input bit pl, input int x, input int y,
                                         input logic [2:0] c);
        logic [31:0] xv;
        logic [31:0] yv;
        xv = x;
        yv = y;
        return {dn, pl, xv[7:0], yv[6:0], c};
    endfunction

    function automatic logic [19:0] obs_pack();
        return {dif.done, dif.vga_plot, dif.vga_x, dif.vga_y, dif.vga_colour};
    endfunction

    // Reference midpoint circle: eight points per step in the fixed octant order.
    task automatic build_model(input int cx, input int cy, input int r, input logic [2:0] col);
        int ox, oy, d, px, py;
        bit pl;
        exp_q.delete();
        ox = r;
        oy = 0;
        d  = 1 - r;
        do begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - ox; py = cy + oy; end
                    3: begin px = cx - oy; py = cy + ox; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + ox; py = cy - oy; end
                    default: begin px = cx + oy; py = cy - ox; end
                endcase
                pl = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
                exp_q.push_back(pack(1'b0, pl, px, py, col));
            end
            oy = oy + 1;
            if (d <= 0) begin
                d = d + 2 * oy + 1;
            end else begin
                ox = ox - 1;
                d = d + 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    task automatic start_draw(input int cx, input int cy, input int r, input logic [2:0] col);
        dif.centre_x = 8'(cx);
        dif.centre_y = 7'(cy);
        dif.radius   = 8'(r);
        dif.colour   = col;
        dif.start    = 1'b1;
        tick();
    endtask

    // Compares the pixel stream from index skip to the end of the model, then done.
    task automatic run_check(input string tag, input int skip, input int perturb_at,
                             output int obs_plots);
        logic [19:0] o;
        int exp_plots;
        obs_plots = 0;
        exp_plots = 0;
        for (int i = skip; i < exp_q.size(); i++) begin
            if (i == perturb_at) begin
                dif.centre_x = 8'd10;
                dif.centre_y = 7'd5;
                dif.radius   = 8'd3;
                dif.colour   = 3'b111;
            end
            o = obs_pack();
            chk(tag, o, exp_q[i]);
            if (o[18]) begin
                obs_plots++;
                total++;
                assert (dif.vga_x <= 8'd159 && dif.vga_y <= 7'd119) else begin
                    bad++;
                    $error("FAIL %s_bounds observed=(%0d,%0d) expected on screen",
                           tag, dif.vga_x, dif.vga_y);
                end
            end
            if (exp_q[i][18]) exp_plots++;
            tick();
        end
        chk({tag, "_plots"}, obs_plots, exp_plots);
        chk({tag, "_done"}, obs_pack(), pack(1'b1, 1'b0, 0, 0, 3'b000));
    endtask

    initial begin
        int ex1[8];
        int ey1[8];
        int ex3[8];
        int ey3[8];
        bit ep3[8];
        int plots;

        ex1 = '{120, 80, 40, 80, 40, 80, 120, 80};
        ey1 = '{60, 100, 60, 100, 60, 20, 60, 20};
        ex3 = '{10, 0, -10, 0, -10, 0, 10, 0};
        ey3 = '{0, 10, 0, 10, 0, -10, 0, -10};
        ep3 = '{1, 1, 0, 1, 0, 0, 1, 0};

        dif.start    = 1'b0;
        dif.colour   = '0;
        dif.centre_x = '0;
        dif.centre_y = '0;
        dif.radius   = '0;

        // Reset state
        tick();
        tick();
        chk("reset", obs_pack(), 20'h0);
        rst = 1'b0;
        tick();
        chk("idle", obs_pack(), 20'h0);

        // r=40 at (80,60): first iteration directed, then full model
        build_model(80, 60, 40, 3'b010);
        start_draw(80, 60, 40, 3'b010);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("r40_it0_oct%0d", i), obs_pack(), pack(1'b0, 1'b1, ex1[i], ey1[i], 3'b010));
            tick();
        end
        run_check("r40", 8, -1, plots);
        chk("r40_mod8", (plots + 8) % 8, 0);
        tick();
        chk("r40_hold1", obs_pack(), pack(1'b1, 1'b0, 0, 0, 3'b000));
        tick();
        chk("r40_hold2", obs_pack(), pack(1'b1, 1'b0, 0, 0, 3'b000));
        dif.start = 1'b0;
        tick();
        chk("r40_release", obs_pack(), 20'h0);

        // Corner circle: clipping
        build_model(0, 0, 10, 3'b101);
        start_draw(0, 0, 10, 3'b101);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("corner_oct%0d", i), obs_pack(), pack(1'b0, ep3[i], ex3[i], ey3[i], 3'b101));
            tick();
        end
        run_check("corner", 8, -1, plots);
        dif.start = 1'b0;
        tick();
        chk("corner_release", obs_pack(), 20'h0);

        // Radius zero
        start_draw(5, 7, 0, 3'b001);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("r0_oct%0d", i), obs_pack(), pack(1'b0, 1'b1, 5, 7, 3'b001));
            tick();
        end
        chk("r0_done", obs_pack(), pack(1'b1, 1'b0, 0, 0, 3'b000));
        dif.start = 1'b0;
        tick();
        chk("r0_release", obs_pack(), 20'h0);

        // Reset during OCT3
        start_draw(80, 60, 40, 3'b010);
        tick();
        tick();
        tick();
        chk("rst_oct3", obs_pack(), pack(1'b0, 1'b1, 80, 100, 3'b010));
        rst = 1'b1;
        dif.start = 1'b0;
        tick();
        chk("rst_abort", obs_pack(), 20'h0);
        rst = 1'b0;
        tick();
        chk("rst_idle", obs_pack(), 20'h0);
        build_model(80, 60, 40, 3'b010);
        start_draw(80, 60, 40, 3'b010);
        chk("rst_redraw", obs_pack(), pack(1'b0, 1'b1, 120, 60, 3'b010));
        tick();
        run_check("rst_rest", 1, -1, plots);
        dif.start = 1'b0;
        tick();
        chk("rst_release", obs_pack(), 20'h0);

        // Inputs perturbed mid-draw must not affect the stream
        build_model(80, 60, 40, 3'b010);
        start_draw(80, 60, 40, 3'b010);
        run_check("perturb", 0, 50, plots);
        dif.start = 1'b0;
        tick();
        chk("perturb_release", obs_pack(), 20'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
